// File: rtl/baud_gen_param.sv
// Baud-rate generator: a divisor prescaler drives oversample ticks, plus mid-bit sample and
// end-of-bit strobes. A divisor change staged while counting takes effect at a tick boundary.
module baud_gen_param #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  input  logic                 resync,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic                 baud_clk,
  output logic                 load_pending,
  output logic                 load_err
);

  localparam int unsigned OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] MID_IDX = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] BIT_IDX = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] HALF    = OW'(OVERSAMPLE / 2);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] div_act;
  logic [DIV_WIDTH-1:0] div_shadow;
  logic [DIV_WIDTH-1:0] pcnt;
  logic [OW-1:0]        ocnt;
  logic [OW-1:0]        ocnt_next;
  logic                 valid_load;
  logic                 wrap;

  // The >= compare keeps the prescaler from running away if div_act is lowered
  // below the current count by a direct (idle) load.
  always_comb begin
    valid_load = div_load && (div_in != '0);
    wrap       = en && !resync && (pcnt >= div_act - DIV_WIDTH'(1));
    ocnt_next  = ocnt + OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_act      <= DEF_DIV;
      div_shadow   <= DEF_DIV;
      pcnt         <= '0;
      ocnt         <= '0;
      os_tick      <= 1'b0;
      mid_tick     <= 1'b0;
      bit_tick     <= 1'b0;
      baud_clk     <= 1'b0;
      load_pending <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      load_err <= div_load && (div_in == '0);
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;

      if (resync) begin
        pcnt     <= '0;
        ocnt     <= '0;
        baud_clk <= 1'b0;
      end else if (en) begin
        if (wrap) begin
          pcnt     <= '0;
          ocnt     <= ocnt_next;
          os_tick  <= 1'b1;
          mid_tick <= (ocnt == MID_IDX);
          bit_tick <= (ocnt == BIT_IDX);
          baud_clk <= (ocnt_next >= HALF);
        end else begin
          pcnt <= pcnt + DIV_WIDTH'(1);
        end
      end

      // A pending value is consumed at the wrap first; a load arriving on the
      // same edge then re-stages, so it lands at the following wrap.
      if (wrap && load_pending) begin
        div_act      <= div_shadow;
        load_pending <= 1'b0;
      end
      if (valid_load) begin
        if (!en || resync) begin
          div_act      <= div_in;
          load_pending <= 1'b0;
        end else begin
          div_shadow   <= div_in;
          load_pending <= 1'b1;
        end
      end else if (!en && load_pending) begin
        div_act      <= div_shadow;
        load_pending <= 1'b0;
      end
    end
  end

endmodule
